// File: rtl/cmd_multi_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_multi_pulse_gen
//  Purpose  : Decodes a command bus against CH_NUM effect words and runs one
//             independent pulse channel per word. A rising match loads a
//             per-channel down-counter, and the output stays high while the
//             counter is non-zero. The block also provides retrigger, a global
//             abort, done strobes and dropped-trigger strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_multi_pulse_gen #(
  parameter int CH_NUM    = 4,
  parameter int CMD_WIDTH = 16,
  parameter int CNT_WIDTH = 8,
  // Channel i sits at [i*CMD_WIDTH +: CMD_WIDTH]. Channel 0 is the rightmost
  // word of the concatenation.
  parameter logic [CH_NUM*CMD_WIDTH-1:0] EFFECT_CMD =
    {16'h00ff, 16'ha5a5, 16'h5a5a, 16'h55aa},
  // Pulse length in clocks per channel. A length of 0 disables the channel.
  parameter logic [CH_NUM*CNT_WIDTH-1:0] LAST_CYC =
    {8'd0, 8'd10, 8'd1, 8'd5},
  parameter bit RETRIGGER = 1'b0
) (
  input  logic                 Clk_In,
  input  logic                 Rst,
  input  logic [CMD_WIDTH-1:0] Cmd_In,
  input  logic                 Cmd_En,
  input  logic                 Abort_All,
  output logic [CH_NUM-1:0]    Output_Valid_Sig,
  output logic [CH_NUM-1:0]    Done_Pulse,
  output logic [CH_NUM-1:0]    Trig_Ignored
);

  localparam logic [CNT_WIDTH-1:0] C_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    localparam logic [CMD_WIDTH-1:0] C_EFFECT = EFFECT_CMD[i*CMD_WIDTH +: CMD_WIDTH];
    localparam logic [CNT_WIDTH-1:0] C_LAST   = LAST_CYC[i*CNT_WIDTH +: CNT_WIDTH];

    logic                 match;
    logic                 trig;
    logic                 match_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 done_q;
    logic                 done_d;
    logic                 ign_q;
    logic                 ign_d;

    // Edge-detect the decoded command, then resolve the counter priority.
    always_comb begin
      match = Cmd_En && (Cmd_In == C_EFFECT);
      trig  = match && !match_q;
      cnt_d = cnt_q;
      if (Abort_All) begin
        cnt_d = '0;
      end else if (trig && ((cnt_q == '0) || RETRIGGER)) begin
        cnt_d = C_LAST;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - C_ONE;
      end
      // The done strobe fires only when the final count expires naturally.
      // A reload at cnt==1 keeps cnt_d non-zero, so it suppresses the strobe.
      done_d = !Abort_All && (cnt_q == C_ONE) && (cnt_d == '0);
      // An abort discards a coincident trigger without reporting it.
      ign_d  = !Abort_All && trig &&
               ((!RETRIGGER && (cnt_q != '0)) || (C_LAST == '0));
    end

    // Match history, counter and strobes. The match history updates even
    // during an abort, so a held command does not fire again afterwards.
    always_ff @(posedge Clk_In) begin
      if (Rst) begin
        match_q <= 1'b0;
        cnt_q   <= '0;
        done_q  <= 1'b0;
        ign_q   <= 1'b0;
      end else begin
        match_q <= match;
        cnt_q   <= cnt_d;
        done_q  <= done_d;
        ign_q   <= ign_d;
      end
    end

    assign Output_Valid_Sig[i] = (cnt_q != '0);
    assign Done_Pulse[i]       = done_q;
    assign Trig_Ignored[i]     = ign_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_multi_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmd_multi_pulse_gen
//  Purpose  : Directed bench for cmd_multi_pulse_gen. It runs one instance
//             without retrigger and one with retrigger from shared stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_multi_pulse_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd = 16'h0;
  logic        en  = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  v0, d0, g0, v1, d1, g1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0;

  int hi      [2][4];
  int rise    [2][4];
  int dn      [2][4];
  int ig      [2][4];
  int first_hi[2][4];
  int dn_cyc  [2][4];
  int ig_cyc  [2][4];
  bit pv      [2][4];

  always #5 clk = ~clk;

  cmd_multi_pulse_gen #(
    .CH_NUM(4), .CMD_WIDTH(16), .CNT_WIDTH(8),
    .EFFECT_CMD({16'h00ff, 16'ha5a5, 16'h5a5a, 16'h55aa}),
    .LAST_CYC({8'd0, 8'd10, 8'd1, 8'd5}),
    .RETRIGGER(1'b0)
  ) dut0 (
    .Clk_In(clk), .Rst(rst), .Cmd_In(cmd), .Cmd_En(en), .Abort_All(abort),
    .Output_Valid_Sig(v0), .Done_Pulse(d0), .Trig_Ignored(g0)
  );

  cmd_multi_pulse_gen #(
    .CH_NUM(4), .CMD_WIDTH(16), .CNT_WIDTH(8),
    .EFFECT_CMD({16'h00ff, 16'ha5a5, 16'h5a5a, 16'h55aa}),
    .LAST_CYC({8'd0, 8'd10, 8'd1, 8'd5}),
    .RETRIGGER(1'b1)
  ) dut1 (
    .Clk_In(clk), .Rst(rst), .Cmd_In(cmd), .Cmd_En(en), .Abort_All(abort),
    .Output_Valid_Sig(v1), .Done_Pulse(d1), .Trig_Ignored(g1)
  );

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        hi[d][c] = 0; rise[d][c] = 0; dn[d][c] = 0; ig[d][c] = 0;
        first_hi[d][c] = -1; dn_cyc[d][c] = -1; ig_cyc[d][c] = -1;
      end
    end
  endtask

  // Advance one clock, then sample the outputs 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        bit vb, db, gb;
        vb = (d == 0) ? v0[c] : v1[c];
        db = (d == 0) ? d0[c] : d1[c];
        gb = (d == 0) ? g0[c] : g1[c];
        if (vb) begin
          hi[d][c]++;
          if (!pv[d][c]) begin
            rise[d][c]++;
            if (first_hi[d][c] < 0) first_hi[d][c] = cyc;
          end
        end
        pv[d][c] = vb;
        if (db) begin
          dn[d][c]++;
          if (dn_cyc[d][c] < 0) dn_cyc[d][c] = cyc;
        end
        if (gb) begin
          ig[d][c]++;
          if (ig_cyc[d][c] < 0) ig_cyc[d][c] = cyc;
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(2);
    checks++;
    if ({v0, d0, g0, v1, d1, g1} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000000", {v0, d0, g0, v1, d1, g1});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_pulse();
    clear_stats();
    en = 1'b1; cmd = 16'h55aa; t0 = cyc + 1;
    ticks(4);
    cmd = 16'h0;
    ticks(8);
    checks++;
    if (hi[0][0] !== 5 || rise[0][0] !== 1) begin
      errors++;
      $display("FAIL basic_len: got hi=%0d rise=%0d expected hi=5 rise=1", hi[0][0], rise[0][0]);
    end
    checks++;
    if (first_hi[0][0] !== t0) begin
      errors++;
      $display("FAIL basic_start: got cycle %0d expected %0d", first_hi[0][0], t0);
    end
    checks++;
    if (dn[0][0] !== 1 || dn_cyc[0][0] !== t0 + 5) begin
      errors++;
      $display("FAIL basic_done: got n=%0d at %0d expected n=1 at %0d", dn[0][0], dn_cyc[0][0], t0 + 5);
    end
    checks++;
    if (hi[0][1] + hi[0][2] + hi[0][3] + hi[1][1] + hi[1][2] + hi[1][3] !== 0) begin
      errors++;
      $display("FAIL basic_others: got %0d high cycles on other channels expected 0",
               hi[0][1] + hi[0][2] + hi[0][3] + hi[1][1] + hi[1][2] + hi[1][3]);
    end
    checks++;
    if (hi[1][0] !== 5 || dn[1][0] !== 1) begin
      errors++;
      $display("FAIL basic_rt_inst: got hi=%0d dn=%0d expected hi=5 dn=1", hi[1][0], dn[1][0]);
    end
  endtask

  task automatic test_retrigger();
    clear_stats();
    cmd = 16'ha5a5; t0 = cyc + 1;
    tick();
    cmd = 16'h0;
    ticks(3);
    cmd = 16'ha5a5;
    tick();
    cmd = 16'h0;
    ticks(15);
    // Without retrigger the second trigger is dropped.
    checks++;
    if (hi[0][2] !== 10 || ig[0][2] !== 1 || ig_cyc[0][2] !== t0 + 4) begin
      errors++;
      $display("FAIL noretrig_ign: got hi=%0d ign=%0d at %0d expected hi=10 ign=1 at %0d",
               hi[0][2], ig[0][2], ig_cyc[0][2], t0 + 4);
    end
    checks++;
    if (dn[0][2] !== 1 || dn_cyc[0][2] !== t0 + 10) begin
      errors++;
      $display("FAIL noretrig_done: got n=%0d at %0d expected n=1 at %0d", dn[0][2], dn_cyc[0][2], t0 + 10);
    end
    // With retrigger the second trigger reloads the counter and the pulse stays continuous.
    checks++;
    if (hi[1][2] !== 14 || rise[1][2] !== 1 || ig[1][2] !== 0) begin
      errors++;
      $display("FAIL retrig_len: got hi=%0d rise=%0d ign=%0d expected 14 1 0",
               hi[1][2], rise[1][2], ig[1][2]);
    end
    checks++;
    if (dn[1][2] !== 1 || dn_cyc[1][2] !== t0 + 14) begin
      errors++;
      $display("FAIL retrig_done: got n=%0d at %0d expected n=1 at %0d", dn[1][2], dn_cyc[1][2], t0 + 14);
    end
  endtask

  task automatic test_disabled_channel();
    clear_stats();
    cmd = 16'h00ff;
    ticks(3);
    cmd = 16'h0;
    ticks(3);
    checks++;
    if (hi[0][3] !== 0 || dn[0][3] !== 0 || ig[0][3] !== 1 || ig[1][3] !== 1) begin
      errors++;
      $display("FAIL disabled_ch: got hi=%0d dn=%0d ign0=%0d ign1=%0d expected 0 0 1 1",
               hi[0][3], dn[0][3], ig[0][3], ig[1][3]);
    end
  endtask

  task automatic test_short_and_abort();
    clear_stats();
    cmd = 16'h5a5a;
    tick();
    cmd = 16'h0;
    ticks(3);
    checks++;
    if (hi[0][1] !== 1 || dn[0][1] !== 1 || hi[1][1] !== 1) begin
      errors++;
      $display("FAIL one_clk: got hi=%0d dn=%0d hi_rt=%0d expected 1 1 1", hi[0][1], dn[0][1], hi[1][1]);
    end
    clear_stats();
    cmd = 16'h55aa;
    tick();
    cmd = 16'h0;
    ticks(2);
    abort = 1'b1;
    tick();
    checks++;
    if (v0[0] !== 1'b0 || v1[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: got v0=%b v1=%b expected 0 0", v0[0], v1[0]);
    end
    abort = 1'b0;
    ticks(8);
    checks++;
    if (hi[0][0] !== 3 || dn[0][0] !== 0 || dn[1][0] !== 0) begin
      errors++;
      $display("FAIL abort_done: got hi=%0d dn0=%0d dn1=%0d expected 3 0 0", hi[0][0], dn[0][0], dn[1][0]);
    end
  endtask

  task automatic test_reset_mid_pulse();
    clear_stats();
    cmd = 16'h55aa; en = 1'b1;
    ticks(2);
    rst = 1'b1;
    tick();
    checks++;
    if (v0 !== 4'h0 || v1 !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset_clear: got v0=%h v1=%h expected 0 0", v0, v1);
    end
    tick();
    rst = 1'b0;
    clear_stats();
    t0 = cyc + 1;
    ticks(10);
    checks++;
    if (hi[0][0] !== 5 || first_hi[0][0] !== t0 || dn[0][0] !== 1) begin
      errors++;
      $display("FAIL post_reset_pulse: got hi=%0d start=%0d dn=%0d expected 5 %0d 1",
               hi[0][0], first_hi[0][0], dn[0][0], t0);
    end
    // Re-arm the edge detector, then present the command with no qualifier.
    cmd = 16'h0;
    tick();
    clear_stats();
    cmd = 16'h55aa; en = 1'b0;
    ticks(8);
    checks++;
    if (hi[0][0] !== 0 || hi[1][0] !== 0) begin
      errors++;
      $display("FAIL no_enable: got hi0=%0d hi1=%0d expected 0 0", hi[0][0], hi[1][0]);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) pv[d][c] = 1'b0;
    clear_stats();
    test_reset();
    test_basic_pulse();
    test_retrigger();
    test_disabled_channel();
    test_short_and_abort();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
